mod_matrix_accum: RTL and testbench
===================================

# mod_matrix_accum

Time-multiplexed modulation-matrix accumulator for the FM operator array. Once per sample frame it sweeps every destination operator. For each destination it drives the source-select of the upstream integer-select operator mux across all sources, scales each returned sample by a per-route signed gain, and accumulates the results. It then emits one saturated modulation word per destination to the operator phase-modulation inputs.

## Interface
- OPERATORS, 8: number of operators, used as both sources and destinations; range 2..16, bounded by the 4-bit select.
- DWIDTH, 16: sample width, signed two's complement.
- GWIDTH, 8: gain width, signed Q1.(GWIDTH-1); 127 ≈ +0.992, -128 = -1.0.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- select  out  4  source index to the operator mux; registered.
- mux_data  in  DWIDTH  selected operator sample; combinational return for the current select.
- gain  in  GWIDTH x OPERATORS*OPERATORS  route gains, flat array; entry d*OPERATORS+s is the gain from source s to destination d; must be stable while busy.
- mod_out  out  DWIDTH  saturated modulation word.
- mod_dest  out  4  destination index of mod_out.
- mod_valid  out  1  one-cycle strobe qualifying mod_out and mod_dest.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle strobe, coincident with the mod_valid for the last destination.

## Operation
- States:
  - IDLE: on start go to RUN with dest=0, src=0, acc=0.
  - RUN: select=src. Each cycle, prod <= mux_data*gain[dest*OPERATORS+src] (full-width signed, registered). acc += previous prod. src increments. After src=OPERATORS-1 go to DRAIN.
  - DRAIN: compute final = acc+prod, shift it, saturate it, and register it to mod_out. Pulse mod_valid and set mod_dest=dest. Clear acc and src. If dest<OPERATORS-1: dest++ and go to RUN. Otherwise pulse frame_done and go to IDLE.
- Widths:
  - prod is DWIDTH+GWIDTH bits.
  - acc is DWIDTH+GWIDTH+clog2(OPERATORS) bits; it cannot overflow.
  - Result = acc >>> (GWIDTH-1), arithmetic shift, rounding toward -inf.
  - Result is clamped to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
- The first RUN cycle of each destination does not add a prod (the pipeline is empty). Prod from the previous destination never leaks into the next one.
- In DRAIN, select holds the last source value. The mux output is ignored during DRAIN.
- start while busy is ignored, with no queueing.
- Reset at any time, including mid-frame, aborts the frame on the next edge. The partial result is never emitted.
- Reset values: select=0, mod_out=0, mod_dest=0, mod_valid=0, busy=0, frame_done=0; state=IDLE; acc=0, prod=0.

## Timing
- Let start be sampled in cycle 0.
  - Cycles 1..OPERATORS: RUN for dest 0, select=0..OPERATORS-1.
  - Cycle OPERATORS+1: DRAIN.
- Destination d: mod_valid is visible in cycle (OPERATORS+1)*(d+1)+1. For OPERATORS=8 that is cycles 10, 19, …, 73.
- Frame length: OPERATORS*(OPERATORS+1) busy cycles (72 for the default). busy is high in cycles 1..72.
- frame_done and the last mod_valid are visible in cycle 73; busy is low there. A start in cycle 73 is accepted.
- mod_out and mod_dest hold their value until the next mod_valid.
- Latency from select to the accumulate is 2 cycles: mux sampled into prod, then prod added.

## Test plan
All scenarios use OPERATORS=8, DWIDTH=16, GWIDTH=8. The bench models the mux with source s = in_data[s].
- Reset, then start with all gains 0: mod_valid in cycles 10, 19, …, 73 with mod_dest 0..7; mod_out=0; frame_done only in cycle 73; busy high in cycles 1..72.
- Identity routing: gain[d*8+d]=127, other gains 0, in_data[s]=1000*(s+1): mod_out for dest 0..7 = 992, 1984, 2976, 3968, 4960, 5953, 6945, 7937.
- Saturation:
  - All gains 127, all sources 32767: every mod_out = 32767.
  - All sources -32768, gains 127: every mod_out = -32768.
  - Gains -128, sources -32768: every mod_out = 32767.
- Pipeline isolation: source 7 = 10000 with gain[0*8+7]=127, all other gains 0: dest 0 = 9921, dest 1 = 0, confirming no carry of prod into the next destination.
- start pulsed in cycles 5 and 40 is ignored, with exactly 8 mod_valid pulses. start in cycle 73 begins a new frame with the first mod_valid in cycle 83.
- reset asserted in cycle 30: all outputs take their reset values from cycle 31, with no mod_valid and no frame_done afterwards. A later start produces a complete, correct frame.

Source files
------------

// File: rtl/mod_matrix_accum.sv
// mod_matrix_accum
// Time-multiplexed modulation-matrix accumulator. Once per frame it sweeps
// every destination operator, steps the upstream operator mux through all
// sources, scales each returned sample by the per-route signed gain and
// accumulates. One saturated modulation word is emitted per destination.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   start         frame request, sampled only while idle
//   select        registered source index driven to the operator mux
//   mux_data      combinational mux return for the current select
//   gain          flat route gains, entry d*OPERATORS+s = source s -> dest d
//   mod_out       saturated modulation word (held until the next mod_valid)
//   mod_dest      destination index qualifying mod_out
//   mod_valid     one-cycle strobe for mod_out/mod_dest
//   busy          high while a frame is in progress
//   frame_done    one-cycle strobe with the last destination's mod_valid
module mod_matrix_accum #(
  parameter int unsigned OPERATORS = 8,
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned GWIDTH    = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic [3:0]                            select,
  input  logic [DWIDTH-1:0]                     mux_data,
  input  logic [OPERATORS*OPERATORS*GWIDTH-1:0] gain,
  output logic [DWIDTH-1:0]                     mod_out,
  output logic [3:0]                            mod_dest,
  output logic                                  mod_valid,
  output logic                                  busy,
  output logic                                  frame_done
);

  localparam int unsigned PW = DWIDTH + GWIDTH;
  localparam int unsigned AW = PW + $clog2(OPERATORS);
  localparam logic [3:0] LAST = 4'(OPERATORS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               src_q, src_d;
  logic [3:0]               dest_q, dest_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic signed [PW-1:0]     prod_q, prod_d;
  logic [DWIDTH-1:0]        mod_out_q, mod_out_d;
  logic [3:0]               mod_dest_q, mod_dest_d;
  logic                     mod_valid_q, mod_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     busy_q, busy_d;

  logic [GWIDTH-1:0]        gain_sel;
  logic signed [PW-1:0]     mux_ext;
  logic signed [PW-1:0]     gain_ext;
  logic signed [AW-1:0]     prod_ext;
  logic signed [AW-1:0]     final_sum;
  logic signed [AW-1:0]     shifted;
  logic [DWIDTH-1:0]        sat_word;

  // Route gain for the (dest, src) pair currently being processed.
  always_comb begin
    gain_sel = '0;
    for (int unsigned d = 0; d < OPERATORS; d++) begin
      for (int unsigned s = 0; s < OPERATORS; s++) begin
        if (dest_q == 4'(d) && src_q == 4'(s)) begin
          gain_sel = gain[(d*OPERATORS+s)*GWIDTH +: GWIDTH];
        end
      end
    end
  end

  // Operands sign-extended to the product width so the multiply is exact.
  assign mux_ext   = {{GWIDTH{mux_data[DWIDTH-1]}}, mux_data};
  assign gain_ext  = {{DWIDTH{gain_sel[GWIDTH-1]}}, gain_sel};
  assign prod_ext  = {{(AW-PW){prod_q[PW-1]}}, prod_q};
  assign final_sum = acc_q + prod_ext;
  // Arithmetic shift drops the Q1.(GWIDTH-1) fraction, rounding toward -inf.
  assign shifted   = final_sum >>> (GWIDTH-1);

  always_comb begin
    if (shifted > SAT_MAX) begin
      sat_word = SAT_MAX[DWIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_word = SAT_MIN[DWIDTH-1:0];
    end else begin
      sat_word = shifted[DWIDTH-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dest_d       = dest_q;
    acc_d        = acc_q;
    prod_d       = prod_q;
    mod_out_d    = mod_out_q;
    mod_dest_d   = mod_dest_q;
    mod_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          src_d   = '0;
          dest_d  = '0;
          acc_d   = '0;
          prod_d  = '0;
        end
      end
      RUN: begin
        prod_d = mux_ext * gain_ext;
        // At src 0 the product register still holds nothing of this
        // destination, so it is discarded rather than accumulated.
        if (src_q == '0) begin
          acc_d = '0;
        end else begin
          acc_d = final_sum;
        end
        if (src_q == LAST) begin
          state_d = DRAIN;
        end else begin
          src_d = src_q + 4'd1;
        end
      end
      DRAIN: begin
        mod_out_d   = sat_word;
        mod_dest_d  = dest_q;
        mod_valid_d = 1'b1;
        acc_d       = '0;
        prod_d      = '0;
        src_d       = '0;
        if (dest_q == LAST) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          dest_d  = dest_q + 4'd1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dest_q       <= '0;
      acc_q        <= '0;
      prod_q       <= '0;
      mod_out_q    <= '0;
      mod_dest_q   <= '0;
      mod_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dest_q       <= dest_d;
      acc_q        <= acc_d;
      prod_q       <= prod_d;
      mod_out_q    <= mod_out_d;
      mod_dest_q   <= mod_dest_d;
      mod_valid_q  <= mod_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign select     = src_q;
  assign mod_out    = mod_out_q;
  assign mod_dest   = mod_dest_q;
  assign mod_valid  = mod_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mod_matrix_accum.sv
// Testbench for mod_matrix_accum (OPERATORS=8, DWIDTH=16, GWIDTH=8).
// Expected words come from a matrix-product reference model; a scoreboard
// queue carries (cycle, dest, value) entries to an independent monitor.
module tb_mod_matrix_accum;

  localparam int N = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [3:0]           select;
  logic [15:0]          mux_data;
  logic [N*N*8-1:0]     gain_vec;
  logic [15:0]          mod_out;
  logic [3:0]           mod_dest;
  logic                 mod_valid;
  logic                 busy;
  logic                 frame_done;

  logic signed [15:0]   in_data [N];
  logic signed [7:0]    gains [N*N];

  typedef struct {
    int     cyc;
    int     dest;
    longint val;
    bit     last;
  } exp_t;

  exp_t   sb [$];
  exp_t   e;
  int     cyc = 0;
  int     tests = 0;
  int     fails = 0;
  int     busy_lo = 0;
  int     busy_hi = -1;
  bit     mon_en = 1'b0;
  longint hold_out = 0;
  longint hold_dest = 0;

  mod_matrix_accum #(.OPERATORS(N), .DWIDTH(16), .GWIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .select    (select),
    .mux_data  (mux_data),
    .gain      (gain_vec),
    .mod_out   (mod_out),
    .mod_dest  (mod_dest),
    .mod_valid (mod_valid),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mux_data = in_data[select[2:0]];

  always_comb begin
    gain_vec = '0;
    for (int i = 0; i < N*N; i++) gain_vec[i*8 +: 8] = gains[i];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: out[d] = clamp(floor(sum_s in[s]*g[d][s] / 128)).
  function automatic longint model(input int d);
    longint sum = 0;
    for (int s = 0; s < N; s++) sum += longint'(in_data[s]) * longint'(gains[d*N+s]);
    sum = sum >>> 7;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one cycle; the model decides whether it is accepted.
  task automatic pulse_start();
    if (cyc > busy_hi) begin
      for (int d = 0; d < N; d++)
        sb.push_back('{cyc: cyc + (N+1)*(d+1) + 1, dest: d, val: model(d), last: (d == N-1)});
      busy_lo = cyc + 1;
      busy_hi = cyc + N*(N+1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_frame();
    pulse_start();
    repeat (N*(N+1)) step();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_select"}, longint'(select), 0);
    chk({tag, "_mod_out"}, longint'(mod_out), 0);
    chk({tag, "_mod_dest"}, longint'(mod_dest), 0);
    chk({tag, "_mod_valid"}, longint'(mod_valid), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_frame_done"}, longint'(frame_done), 0);
  endtask

  task automatic set_data(input int kind);
    for (int i = 0; i < N*N; i++) gains[i] = '0;
    for (int s = 0; s < N; s++) in_data[s] = '0;
    case (kind)
      0: for (int s = 0; s < N; s++) in_data[s] = 16'($urandom);
      1: begin
        for (int s = 0; s < N; s++) in_data[s] = 16'(1000*(s+1));
        for (int d = 0; d < N; d++) gains[d*N+d] = 8'sd127;
      end
      2: begin
        for (int s = 0; s < N; s++) in_data[s] = 16'sd32767;
        for (int i = 0; i < N*N; i++) gains[i] = 8'sd127;
      end
      3: begin
        for (int s = 0; s < N; s++) in_data[s] = -16'sd32768;
        for (int i = 0; i < N*N; i++) gains[i] = 8'sd127;
      end
      4: begin
        for (int s = 0; s < N; s++) in_data[s] = -16'sd32768;
        for (int i = 0; i < N*N; i++) gains[i] = -8'sd128;
      end
      5: begin
        in_data[7] = 16'sd10000;
        gains[7] = 8'sd127;
      end
      6: begin
        for (int s = 0; s < N; s++) in_data[s] = 16'($urandom);
        for (int i = 0; i < N*N; i++) gains[i] = 8'($urandom);
      end
      default: begin
        for (int s = 0; s < N; s++) in_data[s] = 16'($urandom_range(0, 4095)) - 16'sd2048;
        for (int i = 0; i < N*N; i++) gains[i] = 8'($urandom);
      end
    endcase
  endtask

  // Monitor: compares every presented output word against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_valid: dest %0d expected in cycle %0d, not seen", sb[0].dest, sb[0].cyc);
        void'(sb.pop_front());
      end
      chk("busy", longint'(busy), longint'(cyc >= busy_lo && cyc <= busy_hi));
      if (mod_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid (cycle %0d): got mod_dest %0d mod_out %0d expected no output",
                   cyc, mod_dest, $signed(mod_out));
        end else begin
          e = sb.pop_front();
          chk("valid_cycle", longint'(cyc), longint'(e.cyc));
          chk("mod_dest", longint'(mod_dest), longint'(e.dest));
          chk("mod_out", longint'($signed(mod_out)), e.val);
          chk("frame_done", longint'(frame_done), longint'(e.last));
          hold_out  = e.val;
          hold_dest = longint'(e.dest);
        end
      end else begin
        chk("frame_done_idle", longint'(frame_done), 0);
        chk("mod_out_hold", longint'($signed(mod_out)), hold_out);
        chk("mod_dest_hold", longint'(mod_dest), hold_dest);
      end
    end
  end

  initial begin
    int t0;
    reset = 1'b1;
    start = 1'b0;
    set_data(5);
    repeat (3) step();
    @(negedge clk);
    check_reset_vals("rst_init");
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) step();

    // Zero gains, random sources: all outputs zero, full timing check.
    set_data(0);
    run_frame();
    repeat (3) step();

    for (int k = 1; k <= 5; k++) begin
      set_data(k);
      run_frame();
      repeat (2) step();
    end

    // Starts inside a busy frame are ignored; start in cycle 73 is accepted.
    for (int k = 0; k < 2; k++) begin
      set_data(6 + k);
      t0 = cyc;
      pulse_start();
      repeat (4) step();
      pulse_start();
      repeat (34) step();
      pulse_start();
      repeat (32) step();
      chk("cycle73_reached", longint'(cyc - t0), 73);
      set_data(7);
      run_frame();
      repeat (2) step();
    end

    // Reset mid-frame in cycle 30 discards the partial frame.
    set_data(7);
    t0 = cyc;
    pulse_start();
    repeat (29) step();
    reset = 1'b1;
    busy_hi = cyc;
    sb.delete();
    step();
    hold_out = 0;
    hold_dest = 0;
    @(negedge clk);
    check_reset_vals("rst_mid");
    step();
    reset = 1'b0;
    repeat (20) step();

    set_data(6);
    run_frame();
    repeat (3) step();
    set_data(7);
    run_frame();
    repeat (5) step();

    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
